// File: rtl/supercar_key_conditioner.sv
// Button front end for the Supercar scanner: synchronises, debounces and
// edge-detects the three active-low mode keys and registers the selected scan mode.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// REL       | key released and stable
// PRESS_CHK | synced level went high; counting stable cycles before accepting the press
// PRS       | key pressed and stable (key_held=1)
// REL_CHK   | synced level went low; counting stable cycles before accepting the release
module supercar_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [2:0] KEY_n,
  output logic [2:0] key_held,
  output logic [2:0] key_press,
  output logic [1:0] mode,
  output logic       mode_change
);

  typedef enum logic [1:0] {
    REL,
    PRESS_CHK,
    PRS,
    REL_CHK
  } key_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       s;
  key_state_t       state [3];
  logic [CNT_W-1:0] cnt   [3];
  logic [1:0]       press_mode;

  // Synchronisers reset to the released (high) raw level so a key held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync_a <= 3'b111;
      sync_b <= 3'b111;
    end else begin
      sync_a <= KEY_n;
      sync_b <= sync_a;
    end
  end

  assign s = ~sync_b;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= REL;
        cnt[i]   <= '0;
      end
      key_held  <= '0;
      key_press <= '0;
    end else begin
      key_press <= '0;
      for (int i = 0; i < 3; i++) begin
        case (state[i])
          REL: begin
            if (s[i]) begin
              state[i] <= PRESS_CHK;
              cnt[i]   <= CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (!s[i]) begin
              state[i] <= REL;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]     <= PRS;
              cnt[i]       <= '0;
              key_held[i]  <= 1'b1;
              key_press[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          PRS: begin
            if (!s[i]) begin
              state[i] <= REL_CHK;
              cnt[i]   <= CNT_ONE;
            end
          end
          REL_CHK: begin
            if (s[i]) begin
              state[i] <= PRS;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]    <= REL;
              cnt[i]      <= '0;
              key_held[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i]    <= REL;
            cnt[i]      <= '0;
            key_held[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Lowest pressed key wins on simultaneous presses.
  always_comb begin
    press_mode = 2'd0;
    if (key_press[0])      press_mode = 2'd1;
    else if (key_press[1]) press_mode = 2'd2;
    else if (key_press[2]) press_mode = 2'd3;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      mode        <= 2'd0;
      mode_change <= 1'b0;
    end else begin
      mode_change <= 1'b0;
      if (key_press != 3'b000) begin
        mode        <= press_mode;
        mode_change <= (press_mode != mode);
      end
    end
  end

endmodule

// File: tb/tb_supercar_key_conditioner.sv
// Directed and randomized bench for supercar_key_conditioner, checked against a
// run-length debounce model.
module tb_supercar_key_conditioner;

  localparam int D = 4;

  logic       CLOCK_50;
  logic       rst;
  logic [2:0] KEY_n;
  logic [2:0] key_held;
  logic [2:0] key_press;
  logic [1:0] mode;
  logic       mode_change;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [2:0] m_s1 = '0, m_s2 = '0;
  logic [2:0] m_held = '0, m_press = '0;
  logic [1:0] m_mode = '0;
  logic       m_mc = 1'b0;
  int         run [3] = '{0, 0, 0};

  logic [2:0] act;
  int         mc_count;

  supercar_key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .KEY_n      (KEY_n),
    .key_held   (key_held),
    .key_press  (key_press),
    .mode       (mode),
    .mode_change(mode_change)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // A key's debounced level flips once the 2-cycle-delayed pressed level has
  // disagreed with it for D consecutive edges.
  always @(posedge CLOCK_50) begin
    logic [1:0] nm;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_press = '0; m_mode = '0; m_mc = 1'b0;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      m_mc = 1'b0;
      if (m_press != 3'b000) begin
        nm = m_press[0] ? 2'd1 : (m_press[1] ? 2'd2 : 2'd3);
        m_mc = (nm != m_mode);
        m_mode = nm;
      end
      m_press = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_held[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_held[i] = ~m_held[i];
            run[i] = 0;
            if (m_held[i]) m_press[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~KEY_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK_50);
      check("model_key_held", 32'(key_held), 32'(m_held));
      check("model_key_press", 32'(key_press), 32'(m_press));
      check("model_mode", 32'(mode), 32'(m_mode));
      check("model_mode_change", 32'(mode_change), 32'(m_mc));
      act = act | key_press | key_held | {2'b00, mode_change};
      mc_count += int'(mode_change);
    end
  endtask

  initial begin
    rst = 1'b1;
    KEY_n = 3'b111;
    act = '0;
    mc_count = 0;

    // Reset and idle
    tick(2);
    check("rst_held", 32'(key_held), 0);
    check("rst_press", 32'(key_press), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_mc", 32'(mode_change), 0);
    rst = 1'b0;
    act = '0;
    tick(20);
    check("idle_activity", 32'(act), 0);
    check("idle_mode", 32'(mode), 0);

    // Clean press of m1
    KEY_n = 3'b110;
    tick(5);
    check("press_early", 32'(key_press), 0);
    check("held_early", 32'(key_held), 0);
    tick(1);
    check("press_edge6", 32'(key_press), 32'h1);
    check("held_edge6", 32'(key_held), 32'h1);
    check("mode_edge6", 32'(mode), 0);
    tick(1);
    check("press_edge7", 32'(key_press), 0);
    check("mode_edge7", 32'(mode), 1);
    check("mc_edge7", 32'(mode_change), 1);
    tick(1);
    check("mc_edge8", 32'(mode_change), 0);
    tick(2);
    KEY_n = 3'b111;
    tick(5);
    check("held_before_rel", 32'(key_held), 32'h1);
    tick(1);
    check("held_after_rel", 32'(key_held), 0);
    check("mode_after_rel", 32'(mode), 1);

    // Glitch on m2
    act = '0;
    KEY_n = 3'b101;
    tick(3);
    KEY_n = 3'b111;
    tick(10);
    check("glitch_activity", 32'(act), 0);
    check("glitch_mode", 32'(mode), 1);

    // Mode switch to m2, then re-press m2
    mc_count = 0;
    KEY_n = 3'b101;
    tick(6);
    check("m2_press", 32'(key_press), 32'h2);
    tick(1);
    check("m2_mode", 32'(mode), 2);
    tick(1);
    KEY_n = 3'b111;
    tick(8);
    check("m2_mc_count", 32'(mc_count), 1);
    mc_count = 0;
    KEY_n = 3'b101;
    tick(6);
    check("m2_repress", 32'(key_press), 32'h2);
    tick(2);
    check("m2_repress_mode", 32'(mode), 2);
    KEY_n = 3'b111;
    tick(8);
    check("m2_repress_mc_count", 32'(mc_count), 0);

    // Simultaneous m1 and m3
    KEY_n = 3'b010;
    tick(6);
    check("simul_press", 32'(key_press), 32'h5);
    tick(1);
    check("simul_mode", 32'(mode), 1);
    check("simul_mc", 32'(mode_change), 1);
    KEY_n = 3'b111;
    tick(8);

    // Reset mid-debounce with m3 held through it
    act = '0;
    KEY_n = 3'b011;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("midrst_activity", 32'(act & 3'b011), 0);
    check("midrst_press", 32'(key_press), 0);
    check("midrst_mode", 32'(mode), 0);
    rst = 1'b0;
    tick(5);
    check("post_rst_early", 32'(key_press), 0);
    tick(1);
    check("post_rst_press", 32'(key_press), 32'h4);
    tick(1);
    check("post_rst_mode", 32'(mode), 3);
    KEY_n = 3'b111;
    tick(8);

    // Randomized key activity with occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      KEY_n = 3'($urandom_range(0, 7));
      tick(int'($urandom_range(1, 10)));
    end
    KEY_n = 3'b111;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
